// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore FSM sequencing a multicycle ARM-style datapath
module multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic       CondEx,
  input  logic       NoWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUOp,
  output logic       Branch,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       PCWrite,
  output logic       InstrDone,
  output logic       Illegal,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [3:0] State
);
  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEMADR   = 4'd2;
  localparam logic [3:0] MEMREAD  = 4'd3;
  localparam logic [3:0] MEMWB    = 4'd4;
  localparam logic [3:0] MEMWRITE = 4'd5;
  localparam logic [3:0] EXECUTER = 4'd6;
  localparam logic [3:0] EXECUTEI = 4'd7;
  localparam logic [3:0] ALUWB    = 4'd8;
  localparam logic [3:0] BRANCH   = 4'd9;

  logic [3:0] state_q, state_d;
  logic       next_pc, reg_w, mem_w;
  logic       unused_funct;

  assign unused_funct = ^Funct[4:1];

  // next-state selection; unused encodings fall back to FETCH
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:              state_d = DECODE;
      DECODE:             state_d = Op == 2'b00 ? (Funct[5] ? EXECUTEI : EXECUTER) :
                                    Op == 2'b01 ? MEMADR :
                                    Op == 2'b10 ? BRANCH : FETCH;
      MEMADR:             state_d = Funct[0] ? MEMREAD : MEMWRITE;
      MEMREAD:            state_d = MEMWB;
      EXECUTER, EXECUTEI: state_d = ALUWB;
      default:            state_d = FETCH;
    endcase
  end

  // state register, forced to FETCH immediately while reset is low
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= FETCH;
    else        state_q <= state_d;
  end

  // per-state datapath controls, decoded from the state register only
  always_comb begin
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    ALUOp     = 1'b0;
    Branch    = 1'b0;
    next_pc   = 1'b0;
    reg_w     = 1'b0;
    mem_w     = 1'b0;
    case (state_q)
      FETCH: begin
        IRWrite   = 1'b1;
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        next_pc   = 1'b1;
      end
      DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR:   ALUSrcB = 2'b01;
      MEMREAD:  AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        reg_w     = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        mem_w  = 1'b1;
      end
      EXECUTER: ALUOp = 1'b1;
      EXECUTEI: begin
        ALUSrcB = 2'b01;
        ALUOp   = 1'b1;
      end
      ALUWB:    reg_w = 1'b1;
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        Branch    = 1'b1;
      end
      default: ;
    endcase
  end

  assign RegWrite  = reg_w & CondEx & ~NoWrite;
  assign MemWrite  = mem_w & CondEx;
  assign PCWrite   = next_pc | (CondEx & (Branch | (reg_w & (Rd == 4'hF))));
  assign InstrDone = (state_q == MEMWB) | (state_q == MEMWRITE) | (state_q == ALUWB) | (state_q == BRANCH);
  assign Illegal   = (state_q == DECODE) & (Op == 2'b11);
  assign State     = state_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: random and directed instructions checked against a per-class behavioural model
module tb_multicycle_ctrl;
  typedef struct packed {
    logic       irw;
    logic       adr;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic [1:0] res;
    logic       aluop;
    logic       br;
    logic       regwr;
    logic       memwr;
    logic       pcwr;
    logic       done;
    logic       ill;
  } outs_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [1:0] Op = 2'b00;
  logic [5:0] Funct = 6'd0;
  logic [3:0] Rd = 4'd0;
  logic CondEx = 1'b0, NoWrite = 1'b0;
  logic IRWrite, AdrSrc, ALUOp, Branch, RegWrite, MemWrite, PCWrite, InstrDone, Illegal;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
  logic [3:0] State;
  outs_t dut_o;
  int checks = 0, errors = 0;
  int cap_state [8];
  outs_t cap_o [8];
  int cap_n;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .CondEx(CondEx), .NoWrite(NoWrite),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUOp(ALUOp), .Branch(Branch), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .PCWrite(PCWrite), .InstrDone(InstrDone), .Illegal(Illegal),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .State(State)
  );

  assign dut_o = '{IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, Branch, RegWrite, MemWrite, PCWrite, InstrDone, Illegal};

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // the state walk an instruction of each class must take, FETCH included
  function automatic void seq_of(input logic [1:0] op, input logic [5:0] f, output int s[$]);
    s = {0, 1};
    if (op == 2'b00) s = {s, f[5] ? 7 : 6, 8};
    else if (op == 2'b01) s = f[0] ? {s, 2, 3, 4} : {s, 2, 5};
    else if (op == 2'b10) s = {s, 9};
  endfunction

  // output values demanded in a given state for the current instruction fields
  function automatic outs_t model(input int st, input logic [1:0] op, input logic [3:0] rd, input logic c, input logic nw);
    outs_t o = '0;
    logic npc = 0, rw = 0, mw = 0;
    case (st)
      0: begin o.irw = 1; o.srca = 1; o.srcb = 2; o.res = 2; npc = 1; end
      1: begin o.srca = 1; o.srcb = 2; o.res = 2; end
      2: o.srcb = 1;
      3: o.adr = 1;
      4: begin o.res = 1; rw = 1; end
      5: begin o.adr = 1; mw = 1; end
      6: o.aluop = 1;
      7: begin o.srcb = 1; o.aluop = 1; end
      8: rw = 1;
      9: begin o.srcb = 1; o.res = 2; o.br = 1; end
      default: ;
    endcase
    o.regwr = rw && c && !nw;
    o.memwr = mw && c;
    o.pcwr = npc || (c && (o.br || (rw && rd == 15)));
    o.done = st == 4 || st == 5 || st == 8 || st == 9;
    o.ill = st == 1 && op == 3;
    return o;
  endfunction

  task automatic cmp_step(input string tag, input int st, input logic [1:0] op, input logic [3:0] rd, input logic c, input logic nw);
    outs_t e = model(st, op, rd, c, nw);
    checks++;
    if (State !== 4'(st) || dut_o !== e) begin
      errors++;
      $display("FAIL %s: state got %0d expected %0d, outputs got %h expected %h (t=%0t)", tag, State, st, dut_o, e, $time);
    end
  endtask

  // called at a negedge while the DUT is in FETCH; returns at the next FETCH negedge
  task automatic run_instr(input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd, input logic c, input logic nw);
    int s[$];
    Op = op; Funct = f; Rd = rd; CondEx = c; NoWrite = nw;
    seq_of(op, f, s);
    cap_n = s.size();
    #1;
    foreach (s[i]) begin
      if (i > 0) begin @(negedge clk); #1; end
      cmp_step("step", s[i], op, rd, c, nw);
      cap_state[i] = int'(State);
      cap_o[i] = dut_o;
    end
    @(negedge clk);
  endtask

  initial begin
    int nd;
    #1;
    chk("reset_state", State, 0);
    chk("reset_irwrite", IRWrite, 1);
    @(negedge clk);
    reset = 1'b1;
    // data-processing register
    run_instr(2'b00, 6'b001000, 4'd3, 1, 0);
    chk("dp_len", cap_n, 4);
    chk("dp_s2", cap_state[2], 6);
    chk("dp_s3", cap_state[3], 8);
    chk("dp_regwr_exec", cap_o[2].regwr, 0);
    chk("dp_regwr_wb", cap_o[3].regwr, 1);
    nd = 0;
    for (int i = 0; i < 4; i++) nd += int'(cap_o[i].done);
    chk("dp_done_once", nd, 1);
    // LDR to PC
    run_instr(2'b01, 6'b011001, 4'hF, 1, 0);
    chk("ldr_len", cap_n, 5);
    chk("ldr_s3", cap_state[3], 3);
    chk("ldr_s4", cap_state[4], 4);
    chk("ldr_res", cap_o[4].res, 1);
    chk("ldr_regwr", cap_o[4].regwr, 1);
    chk("ldr_pcwr", cap_o[4].pcwr, 1);
    // STR, condition failed
    run_instr(2'b01, 6'b011000, 4'd2, 0, 0);
    chk("str_len", cap_n, 4);
    chk("str_s3", cap_state[3], 5);
    chk("str_memwr", cap_o[3].memwr, 0);
    chk("str_done", cap_o[3].done, 1);
    // STR, condition passed
    run_instr(2'b01, 6'b000000, 4'd2, 1, 0);
    chk("str_memwr_c1", cap_o[3].memwr, 1);
    // CMP
    run_instr(2'b00, 6'b010101, 4'd0, 1, 1);
    chk("cmp_s3", cap_state[3], 8);
    chk("cmp_regwr", cap_o[3].regwr, 0);
    // branches
    run_instr(2'b10, 6'b000000, 4'd0, 1, 0);
    chk("b_len", cap_n, 3);
    chk("b_pcwr_taken", cap_o[2].pcwr, 1);
    run_instr(2'b10, 6'b000000, 4'd0, 0, 0);
    chk("b_pcwr_not", cap_o[2].pcwr, 0);
    // illegal
    run_instr(2'b11, 6'b111111, 4'hF, 1, 0);
    chk("ill_flag", cap_o[1].ill, 1);
    chk("ill_regwr", cap_o[1].regwr, 0);
    chk("ill_memwr", cap_o[1].memwr, 0);
    #1;
    chk("ill_back_fetch", State, 0);
    // reset asserted between edges in MEMREAD
    Op = 2'b01; Funct = 6'b011001; Rd = 4'd4; CondEx = 1; NoWrite = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_pre_memread", State, 3);
    reset = 1'b0;
    #1;
    chk("rst_async_state", State, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_rel_state", State, 0);
    chk("rst_rel_irwrite", IRWrite, 1);
    chk("rst_rel_pcwrite", PCWrite, 1);
    @(negedge clk);
    #1;
    chk("rst_rel_decode", State, 1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    // random instruction stream
    for (int n = 0; n < 300; n++) begin
      logic [3:0] rd;
      rd = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
      run_instr(2'($urandom), 6'($urandom), rd, 1'($urandom), 1'($urandom));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The module SHALL have port clk, input, 1 bit: single clock; all state updates occur on its rising edge.
REQ-002 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset (asserted at 0).
REQ-003 The module SHALL have port Op, input, 2 bits: instruction class from the instruction register (00 data-processing, 01 memory, 10 branch, 11 illegal).
REQ-004 The module SHALL have port Funct, input, 6 bits: instruction bits [25:20] (Funct[5] immediate, Funct[0] L-bit for memory instructions).
REQ-005 The module SHALL have port Rd, input, 4 bits: destination register field.
REQ-006 The module SHALL have port CondEx, input, 1 bit: condition-check result for the current instruction.
REQ-007 The module SHALL have port NoWrite, input, 1 bit: set by the ALU decoder for compare-type instructions.
REQ-008 The module SHALL have ports IRWrite, AdrSrc, ALUOp, Branch, RegWrite, MemWrite, PCWrite, InstrDone and Illegal, each output, 1 bit.
REQ-009 The module SHALL have ports ALUSrcA, ALUSrcB and ResultSrc, each output, 2 bits: datapath mux selects.
REQ-010 The module SHALL have port State, output, 4 bits: current state encoding, for debug.

Function
REQ-011 The FSM SHALL have these states and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9.
REQ-012 Encodings 10-15 SHALL be unreachable; if entered, the next state SHALL be FETCH.
REQ-013 The FSM SHALL use these transitions:
- FETCH->DECODE
- DECODE: Op=00 and Funct[5]=1 -> EXECUTEI; Op=00 and Funct[5]=0 -> EXECUTER; Op=01 -> MEMADR; Op=10 -> BRANCH; Op=11 -> FETCH
- MEMADR: Funct[0]=1 -> MEMREAD; Funct[0]=0 -> MEMWRITE
- MEMREAD->MEMWB
- EXECUTER and EXECUTEI -> ALUWB
- MEMWB, MEMWRITE, ALUWB and BRANCH -> FETCH
REQ-014 Any output not listed for a state in REQ-015 SHALL be 0 in that state.
REQ-015 Each state SHALL assert these outputs:
- FETCH: AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, IRWrite=1, internal NextPC=1
- DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10
- MEMADR: ALUSrcA=00, ALUSrcB=01
- MEMREAD: AdrSrc=1, ResultSrc=00
- MEMWB: ResultSrc=01, internal RegW=1
- MEMWRITE: AdrSrc=1, internal MemW=1
- EXECUTER: ALUSrcA=00, ALUSrcB=00, ALUOp=1
- EXECUTEI: ALUSrcA=00, ALUSrcB=01, ALUOp=1
- ALUWB: ResultSrc=00, internal RegW=1
- BRANCH: ALUSrcA=00, ALUSrcB=01, ResultSrc=10, Branch=1
REQ-016 All state-decoded outputs SHALL be combinational from the state register (Moore); the only inputs that affect outputs SHALL be CondEx, NoWrite and Rd, and only through the gating in REQ-017 to REQ-019.
REQ-017 RegWrite SHALL equal RegW & CondEx & ~NoWrite.
REQ-018 MemWrite SHALL equal MemW & CondEx.
REQ-019 PCWrite SHALL equal NextPC | (CondEx & (Branch | (RegW & Rd==4'hF))).
REQ-020 InstrDone SHALL be 1 for exactly one cycle in MEMWB, MEMWRITE, ALUWB or BRANCH, regardless of CondEx.
REQ-021 Illegal SHALL be 1 in DECODE when Op=11; the FSM SHALL then return to FETCH with no register, memory or PC write beyond the FETCH-cycle PC+4.
REQ-022 Each instruction class SHALL take a fixed number of cycles, FETCH included: branch 3, data-processing 4, STR 4, LDR 5.
REQ-023 Op, Funct and Rd SHALL be sampled only when needed (DECODE, MEMADR, and output gating); they are held stable by the IR while IRWrite=0.

Reset
REQ-024 While reset=0, the state SHALL be FETCH immediately, without waiting for a clock edge.
REQ-025 A reset in any state SHALL abort the instruction in progress, with no partial-write guarantee beyond the cycle already committed.
REQ-026 After reset deasserts, the first rising edge SHALL perform a FETCH, so IRWrite=1 and PCWrite=1 during the first cycle.

Verification
REQ-027 Data-processing register, Op=00, Funct=001000, CondEx=1, NoWrite=0 -> State 0,1,6,8,0; RegWrite=1 only in ALUWB; InstrDone pulses once.
REQ-028 LDR, Op=01, Funct=011001, Rd=15, CondEx=1 -> State 0,1,2,3,4; in MEMWB ResultSrc=01, RegWrite=1 and PCWrite=1.
REQ-029 STR with CondEx=0 -> State 0,1,2,5; MemWrite stays 0; InstrDone=1 in MEMWRITE.
REQ-030 CMP, Op=00, Funct=010101, NoWrite=1 -> passes through ALUWB with RegWrite=0; branch Op=10 with CondEx=1 -> PCWrite=1 in BRANCH; with CondEx=0 -> PCWrite=0.
REQ-031 Op=11 -> Illegal=1 in DECODE, then State returns to 0; no RegWrite or MemWrite is asserted.
REQ-032 Reset driven to 0 mid-MEMREAD, asynchronously between clock edges -> State=0 immediately; after release the next cycle has IRWrite=1.
